aes_key_sched_ctrl: RTL

//  Iterative AES-128 key-schedule controller. It replaces the fully unrolled expander when area matters.
//  - Accepts a 128-bit cipher key over a valid/ready handshake.
//  - Generates w4..w43 at one word per cycle, using one shared RotWord+SubWord unit and a running Rcon register.
//  - Stores the 11 round keys in an internal buffer.
//  - Serves round-key reads to the cipher round sequencer.

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes_key_sched_ctrl_rot_sub_word.sv | 32 +++
 rtl/aes_key_sched_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-128 key-schedule controller:
//   AES_NR / AES_NK / RCON_INIT constants, the controller FSM state enum,
//   the xtime() GF(2^8) doubling helper and the AES S-box lookup.
// Build option: AES_KEY_ZEROIZE_EN (used by aes_key_sched_ctrl only).
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int         AES_NR    = 10;
  localparam int         AES_NK    = 4;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } aes_state_e;

  // Multiply by x in GF(2^8) with the AES polynomial; steps rcon 80 -> 1b -> 36.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    sbox = SBOX_TBL[2047 - 8 * int'(a) -: 8];
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_rot_sub_word.sv
// -----------------------------------------------------------------------------
// aes_sbox / aes_rot_sub_word
// Combinational SubWord(RotWord(w)) for one 32-bit key-schedule word.
//   aes_sbox:         a [7:0] in, y [7:0] out (single S-box lookup)
//   aes_rot_sub_word: word_in [31:0] in, word_out [31:0] out
// One aes_rot_sub_word instance is shared by every expansion step.
// -----------------------------------------------------------------------------
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = sbox(a);
endmodule

module aes_rot_sub_word (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);
  logic [31:0] rot;

  // RotWord: {a0,a1,a2,a3} -> {a1,a2,a3,a0}
  assign rot = {word_in[23:0], word_in[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot[8*b +: 8]),
      .y (word_out[8*b +: 8])
    );
  end
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_sched_ctrl
// Iterative AES-128 key expansion: one schedule word per cycle into a
// 44 x 32-bit buffer, served as 128-bit round-key rows.
// Ports:
//   clk, rst_n            clock (rising), async active-low reset
//   zeroize               (only with AES_KEY_ZEROIZE_EN) wipe buffer, go IDLE
//   key_valid/key_ready   cipher key handshake, key_in[127:0] (w0 = [127:96])
//   busy                  expansion in progress
//   done                  one-cycle pulse when w43 is written
//   keys_valid            buffer holds a complete schedule
//   rk_rd_en/rk_rd_round  round-key read request (round 0..NR)
//   rk_rd_data/valid      registered read response, 1-cycle latency
//   state_dbg             current FSM state, for observation
// Build option: define AES_KEY_ZEROIZE_EN to add the zeroize input.
//
// Handshake: a key transfers on a rising edge where key_valid && key_ready;
// key_ready is high in IDLE and READY, low in EXPAND, and held low while
// rst_n is asserted. key_valid needs no qualification beyond that edge.
// -----------------------------------------------------------------------------
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [4*WORD_W-1:0] key_in,
  output logic                busy,
  output logic                done,
  output logic                keys_valid,
  input  logic                rk_rd_en,
  input  logic [3:0]          rk_rd_round,
  output logic [4*WORD_W-1:0] rk_rd_data,
  output logic                rk_rd_valid,
  output aes_state_e          state_dbg
);

  localparam int         NWORDS    = AES_NK * (NR + 1);
  localparam int         IW        = $clog2(NWORDS + 1);
  localparam logic [3:0] MAX_ROUND = 4'(NR);

  aes_state_e        state, next_state;
  logic [IW-1:0]     wcnt;
  logic [7:0]        rcon;
  logic [WORD_W-1:0] kbuf [NWORDS];

  logic              zclr;
  logic              accept;
  logic              last_word;
  logic [IW-1:0]     prev_idx, back4_idx, row_idx;
  logic [WORD_W-1:0] prev_w, rot_sub_w, temp_w, new_w;

`ifdef AES_KEY_ZEROIZE_EN
  assign zclr = zeroize;
`else
  assign zclr = 1'b0;
`endif

  // Gated by rst_n so every output reads 0 while reset is held.
  assign key_ready = rst_n && (state != EXPAND);
  assign accept    = key_valid && key_ready && !zclr;
  assign last_word = (state == EXPAND) && (wcnt == IW'(NWORDS - 1));
  assign state_dbg = state;

  // Expansion datapath: w[i] = w[i-4] ^ t, t = w[i-1] or its g() transform.
  assign prev_idx  = wcnt - IW'(1);
  assign back4_idx = wcnt - IW'(4);
  assign prev_w    = kbuf[prev_idx];

  aes_rot_sub_word u_rot_sub (
    .word_in  (prev_w),
    .word_out (rot_sub_w)
  );

  assign temp_w = (wcnt[1:0] == 2'b00) ?
                  (rot_sub_w ^ {rcon, {(WORD_W-8){1'b0}}}) : prev_w;
  assign new_w  = kbuf[back4_idx] ^ temp_w;

  assign row_idx = IW'({rk_rd_round, 2'b00});

  always_comb begin
    next_state = state;
    if (zclr) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept)    next_state = EXPAND;
        EXPAND:  if (last_word) next_state = READY;
        READY:   if (accept)    next_state = EXPAND;
        default:                next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wcnt        <= '0;
      rcon        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      keys_valid  <= 1'b0;
      rk_rd_valid <= 1'b0;
      rk_rd_data  <= '0;
    end else begin
      state <= next_state;
      done  <= 1'b0;
      if (zclr) begin
        wcnt        <= '0;
        rcon        <= '0;
        busy        <= 1'b0;
        keys_valid  <= 1'b0;
        rk_rd_valid <= 1'b0;
        rk_rd_data  <= '0;
      end else begin
        // Uses the pre-edge keys_valid, so a read coinciding with a new
        // key still returns the old schedule.
        if (rk_rd_en && keys_valid && (rk_rd_round <= MAX_ROUND)) begin
          rk_rd_valid <= 1'b1;
          rk_rd_data  <= {kbuf[row_idx], kbuf[row_idx + IW'(1)],
                          kbuf[row_idx + IW'(2)], kbuf[row_idx + IW'(3)]};
        end else begin
          rk_rd_valid <= 1'b0;
          rk_rd_data  <= '0;
        end

        if (accept) begin
          wcnt       <= IW'(AES_NK);
          rcon       <= RCON_INIT;
          keys_valid <= 1'b0;
          busy       <= 1'b1;
        end else if (state == EXPAND) begin
          wcnt <= wcnt + IW'(1);
          if (wcnt[1:0] == 2'b00) rcon <= xtime(rcon);
          if (last_word) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            keys_valid <= 1'b1;
          end
        end
      end
    end
  end

  // Buffer has no reset: keys_valid guards readers from stale contents.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NWORDS; j++) begin
      if (zclr) begin
        kbuf[j] <= '0;
      end else if (accept && (j < AES_NK)) begin
        kbuf[j] <= key_in[4*WORD_W-1 - WORD_W*j -: WORD_W];
      end else if ((state == EXPAND) && (wcnt == IW'(j))) begin
        kbuf[j] <= new_w;
      end
    end
  end

endmodule
